stoch_matmul_seq: RTL and testbench

STOCH_MATMUL_SEQ -- requirements
Module: stoch_matmul_seq

---
 rtl/stoch_matmul_seq_pkg.sv | 12 +
 rtl/stoch_matmul_seq_if.sv | 27 ++
 rtl/stoch_matmul_seq_bit_counter.sv | 22 ++
 rtl/stoch_matmul_seq.sv | 108 ++++++++++
 tb/tb_stoch_matmul_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/stoch_matmul_seq_pkg.sv
// Shared state encoding for the stochastic matrix-multiply sequencer.
package stoch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WARM,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/stoch_matmul_seq_if.sv
// Control, datapath-bitstream and result handshake bundle of the sequencer.
// The slave side is the sequencer; the master side drives start/len/Y/out_ready.
interface stoch_matmul_seq_if #(
    parameter int NUM_ROWS = 2,
    parameter int NUM_COLS = 2,
    parameter int LEN_W    = 10
);
    logic                                start;
    logic [LEN_W-1:0]                    len;
    logic [NUM_ROWS*NUM_COLS-1:0]        Y;
    logic                                dp_nRST;
    logic                                dp_en;
    logic                                busy;
    logic [NUM_ROWS*NUM_COLS*LEN_W-1:0]  count;
    logic                                out_valid;
    logic                                out_ready;

    modport master (
        output start, len, Y, out_ready,
        input  dp_nRST, dp_en, busy, count, out_valid
    );

    modport slave (
        input  start, len, Y, out_ready,
        output dp_nRST, dp_en, busy, count, out_valid
    );
endinterface

// File: rtl/stoch_matmul_seq_bit_counter.sv
// Ones counter for one product bitstream; 1-cycle update, clear has priority.
// No backpressure: counts whenever enabled.
module stoch_bit_counter #(
    parameter int LEN_W = 10
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [LEN_W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (!nRST || clear) begin
            count <= '0;
        end else if (enable && bit_in) begin
            count <= count + LEN_W'(1'b1);
        end
    end

endmodule

// File: rtl/stoch_matmul_seq.sv
// Sequencer: clears the datapath, discards PIPE_LAT warm-up cycles, counts ones for len cycles.
// Result valid 1+PIPE_LAT+len edges after start; held in DONE until out_ready.
module stoch_matmul_seq
    import stoch_ctrl_pkg::*;
#(
    parameter int NUM_ROWS = 2,
    parameter int NUM_COLS = 2,
    parameter int LEN_W    = 10,
    parameter int PIPE_LAT = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    stoch_matmul_seq_if.slave bus
);

    localparam int NEL   = NUM_ROWS * NUM_COLS;
    localparam int PL_W  = $clog2(PIPE_LAT + 1);
    localparam int CNT_W = (LEN_W > PL_W) ? LEN_W : PL_W;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tmr, tmr_nxt;
    logic [LEN_W-1:0] len_q, len_nxt;
    logic             clear_cnt;
    logic             run_en;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            tmr   <= '0;
            len_q <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            len_q <= len_nxt;
        end
    end

    // One shared timer: loaded with (cycles-1) on entry to WARM/RUN, leaves at zero.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        len_nxt   = len_q;
        clear_cnt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    len_nxt   = bus.len;
                    clear_cnt = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (PIPE_LAT > 0) begin
                    state_nxt = WARM;
                    tmr_nxt   = CNT_W'(PIPE_LAT - 1);
                end else if (len_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RUN;
                    tmr_nxt   = CNT_W'(len_q) - CNT_W'(1);
                end
            end
            WARM: begin
                if (tmr != '0) begin
                    tmr_nxt = tmr - CNT_W'(1);
                end else if (len_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RUN;
                    tmr_nxt   = CNT_W'(len_q) - CNT_W'(1);
                end
            end
            RUN: begin
                if (tmr == '0) begin
                    state_nxt = DONE;
                end else begin
                    tmr_nxt = tmr - CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign run_en        = (state == RUN);
    assign bus.busy      = (state != IDLE);
    assign bus.dp_en     = (state == WARM) || (state == RUN);
    assign bus.out_valid = (state == DONE);
    assign bus.dp_nRST   = nRST && (state != CLEAR);

    for (genvar k = 0; k < NEL; k++) begin : g_el
        stoch_bit_counter #(
            .LEN_W (LEN_W)
        ) u_cnt (
            .CLK    (CLK),
            .nRST   (nRST),
            .clear  (clear_cnt),
            .enable (run_en),
            .bit_in (bus.Y[k]),
            .count  (bus.count[k*LEN_W +: LEN_W])
        );
    end

endmodule

// File: tb/tb_stoch_matmul_seq.sv
// Directed bench for stoch_matmul_seq: driver pushes expected results, monitor checks on out_valid rise.
module tb_stoch_matmul_seq;

    localparam int NR  = 2;
    localparam int NC  = 2;
    localparam int LW  = 10;
    localparam int PL  = 1;
    localparam int NEL = NR * NC;

    typedef struct {
        logic [NEL*LW-1:0] counts;
        int                edge_at;
        string             name;
    } exp_t;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    stoch_matmul_seq_if #(.NUM_ROWS(NR), .NUM_COLS(NC), .LEN_W(LW)) bus ();

    stoch_matmul_seq #(
        .NUM_ROWS (NR),
        .NUM_COLS (NC),
        .LEN_W    (LW),
        .PIPE_LAT (PL)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    exp_t sb[$];
    int   n_pass   = 0;
    int   n_total  = 0;
    int   edge_cnt = 0;
    logic mon_prev = 1'b0;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [NEL*LW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [NEL*LW-1:0] v;
        v = '0;
        v[0*LW +: LW] = LW'(a);
        v[1*LW +: LW] = LW'(b);
        v[2*LW +: LW] = LW'(c);
        v[3*LW +: LW] = LW'(d);
        return v;
    endfunction

    // c counts cycles after start acceptance: 0 = CLEAR, 1..PL = WARM, then RUN.
    function automatic logic [NEL-1:0] ypat(input int mode, input int c, input int len);
        logic [NEL-1:0] y;
        int r;
        r = c - 1 - PL;
        y = '0;
        case (mode)
            0: y = '1;
            1: y[0] = (r >= 0) && (r < len) && ((r % 2) == 0);
            2: y = (c < 1 + PL) ? '1 : '0;
            default: begin
                for (int k = 0; k < NEL; k++)
                    y[k] = (r >= 0) && (r < len) && ((r % (k + 1)) == 0);
            end
        endcase
        return y;
    endfunction

    // Monitor: one scoreboard entry per rising out_valid.
    initial begin
        forever begin
            @(negedge CLK);
            if (bus.out_valid === 1'b1 && mon_prev !== 1'b1) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_result: out_valid rose at edge %0d, none expected", edge_cnt);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_counts"}, 64'(bus.count), 64'(e.counts));
                    check({e.name, "_latency"}, 64'(edge_cnt), 64'(e.edge_at));
                end
            end
            mon_prev = bus.out_valid;
        end
    end

    task automatic run(input string name, input int len, input int mode,
                       input logic [NEL*LW-1:0] exp, input int hold, input bit poke_busy);
        exp_t e;
        int   acc;
        int   c;
        bit   seen;
        bus.len   = LW'(len);
        bus.Y     = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        acc       = edge_cnt;
        e.counts  = exp;
        e.edge_at = acc + 1 + PL + len;
        e.name    = name;
        sb.push_back(e);
        check({name, "_clear_dp_nRST"}, 64'(bus.dp_nRST), 64'(0));
        check({name, "_clear_dp_en"}, 64'(bus.dp_en), 64'(0));
        check({name, "_clear_busy"}, 64'(bus.busy), 64'(1));
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 200) begin
            bus.Y         = ypat(mode, c, len);
            bus.start     = poke_busy && (c == PL + 2);
            bus.out_ready = (hold == 0);
            tick();
            c++;
            if (c == 1 && PL > 0) begin
                check({name, "_warm_dp_en"}, 64'(bus.dp_en), 64'(1));
                check({name, "_warm_dp_nRST"}, 64'(bus.dp_nRST), 64'(1));
            end
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        bus.start = 1'b0;
        if (!seen) begin
            n_total++;
            $display("FAIL %s_timeout: out_valid not seen within %0d cycles", name, c);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            check({name, "_hold_valid"}, 64'(bus.out_valid), 64'(1));
            check({name, "_hold_count"}, 64'(bus.count), 64'(exp));
            bus.start = (i % 2 == 0);
            tick();
        end
        // Start coincides with the accepting handshake and must be dropped.
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        check({name, "_post_busy"}, 64'(bus.busy), 64'(0));
        check({name, "_post_valid"}, 64'(bus.out_valid), 64'(0));
        tick();
        check({name, "_idle_busy"}, 64'(bus.busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.Y         = '0;
        bus.out_ready = 1'b0;
        nRST          = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_valid", 64'(bus.out_valid), 64'(0));
        check("rst_dp_en", 64'(bus.dp_en), 64'(0));
        check("rst_dp_nRST", 64'(bus.dp_nRST), 64'(0));
        check("rst_count", 64'(bus.count), 64'(0));
        nRST = 1'b1;
        tick();
        check("idle_dp_nRST", 64'(bus.dp_nRST), 64'(1));
        check("idle_busy", 64'(bus.busy), 64'(0));

        run("ones_len8",  8,  0, pack4(8, 8, 8, 8), 0, 1'b0);
        run("len0",       0,  0, pack4(0, 0, 0, 0), 0, 1'b0);
        run("alt_len16",  16, 1, pack4(8, 0, 0, 0), 0, 1'b1);
        run("warm_only",  5,  2, pack4(0, 0, 0, 0), 0, 1'b0);
        run("mixed_len6", 6,  3, pack4(6, 3, 2, 2), 0, 1'b0);
        run("hold_len4",  4,  0, pack4(4, 4, 4, 4), 5, 1'b0);

        // Reset at the start of the third RUN cycle of a len=8 run.
        bus.len   = LW'(8);
        bus.Y     = '1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        check("midrun_count", 64'(bus.count), 64'(pack4(2, 2, 2, 2)));
        check("midrun_busy", 64'(bus.busy), 64'(1));
        nRST = 1'b0;
        tick();
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_count", 64'(bus.count), 64'(0));
        check("midrst_dp_en", 64'(bus.dp_en), 64'(0));
        check("midrst_dp_nRST", 64'(bus.dp_nRST), 64'(0));
        nRST = 1'b1;
        tick();
        check("midrst_rel_dp_nRST", 64'(bus.dp_nRST), 64'(1));

        run("after_reset", 8, 0, pack4(8, 8, 8, 8), 0, 1'b0);

        repeat (3) tick();
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
